// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths, queue entry type and onehot helper for the writeback controller
package rf_wb_pkg;

  localparam int REG_AW   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] a);
    logic [NUM_REGS-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/rf_wb_queue.sv
// rtl/rf_wb_queue.sv - circular buffer of MDU results with squash-by-address and live-address mask
module rf_wb_queue
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  wb_entry_t           push_entry_i,
  input  logic                pop_i,
  input  logic                squash_en_i,
  input  logic [REG_AW-1:0]   squash_addr_i,
  output logic                full_o,
  output logic                empty_o,
  output wb_entry_t           head_o,
  output logic [NUM_REGS-1:0] live_mask_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        entries_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = entries_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Freed slots keep live=0, so the mask only needs to scan live bits.
  always_comb begin
    live_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entries_q[i].live) live_mask_o = live_mask_o | reg_onehot(entries_q[i].addr);
    end
    live_mask_o[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (squash_en_i && entries_q[i].live && (entries_q[i].addr == squash_addr_i))
          entries_q[i].live <= 1'b0;
      end
      if (do_pop)  entries_q[rd_ptr_q].live <= 1'b0;
      if (do_push) entries_q[wr_ptr_q]      <= push_entry_i;
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// rtl/rf_writeback_ctrl.sv - merges ALU writeback and queued MDU results onto the regfile write port
// Optional MDU queue bypass when RF_WB_BYPASS_EN is defined.
module rf_writeback_ctrl
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                alu_wr,
  input  logic [REG_AW-1:0]   alu_addr,
  input  logic [DATA_W-1:0]   alu_data,
  input  logic                mdu_valid,
  output logic                mdu_ready,
  input  logic [REG_AW-1:0]   mdu_addr,
  input  logic [DATA_W-1:0]   mdu_data,
  output logic                rf_wr,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] pend_mask
);

  logic                q_full, q_empty, q_push, q_pop;
  wb_entry_t           q_head, q_push_entry;
  logic [NUM_REGS-1:0] q_live_mask;
  logic                alu_take, mdu_fire, bypass;

  logic                rf_wr_q, rf_wr_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                mdu_out_q, mdu_out_d;

  assign alu_take  = alu_wr & (alu_addr != REG_ZERO);
  assign mdu_ready = ~q_full;
  assign mdu_fire  = mdu_valid & mdu_ready & (mdu_addr != REG_ZERO);

`ifdef RF_WB_BYPASS_EN
  assign bypass = mdu_fire & q_empty & ~alu_wr;
`else
  assign bypass = 1'b0;
`endif

  assign q_push       = mdu_fire & ~bypass;
  assign q_pop        = ~alu_take & ~q_empty;
  assign q_push_entry = '{live: 1'b1, addr: mdu_addr, data: mdu_data};

  // An ALU write kills older queued results to the same register; the push this cycle is younger.
  rf_wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .reset        (reset),
    .push_i       (q_push),
    .push_entry_i (q_push_entry),
    .pop_i        (q_pop),
    .squash_en_i  (alu_take),
    .squash_addr_i(alu_addr),
    .full_o       (q_full),
    .empty_o      (q_empty),
    .head_o       (q_head),
    .live_mask_o  (q_live_mask)
  );

  always_comb begin
    rf_wr_d    = 1'b0;
    rf_waddr_d = REG_ZERO;
    rf_wdata_d = '0;
    mdu_out_d  = 1'b0;
    if (alu_take) begin
      rf_wr_d    = 1'b1;
      rf_waddr_d = alu_addr;
      rf_wdata_d = alu_data;
    end else if (bypass) begin
      rf_wr_d    = 1'b1;
      rf_waddr_d = mdu_addr;
      rf_wdata_d = mdu_data;
      mdu_out_d  = 1'b1;
    end else if (q_pop && q_head.live) begin
      rf_wr_d    = 1'b1;
      rf_waddr_d = q_head.addr;
      rf_wdata_d = q_head.data;
      mdu_out_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_wr_q    <= 1'b0;
      rf_waddr_q <= REG_ZERO;
      rf_wdata_q <= '0;
      mdu_out_q  <= 1'b0;
    end else begin
      rf_wr_q    <= rf_wr_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mdu_out_q  <= mdu_out_d;
    end
  end

  assign rf_wr    = rf_wr_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  // The MDU result sitting on rf_* stays pending until the regfile samples it.
  always_comb begin
    pend_mask = q_live_mask;
    if (mdu_out_q) pend_mask = pend_mask | reg_onehot(rf_waddr_q);
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// tb/tb_rf_writeback_ctrl.sv - directed bench with MDU-queue model and ordered write scoreboard
module tb_rf_writeback_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_wr;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        rf_wr;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pend_mask;

  always #5 clk = ~clk;

  rf_writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_wr   (alu_wr),
    .alu_addr (alu_addr),
    .alu_data (alu_data),
    .mdu_valid(mdu_valid),
    .mdu_ready(mdu_ready),
    .mdu_addr (mdu_addr),
    .mdu_data (mdu_data),
    .rf_wr    (rf_wr),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .pend_mask(pend_mask)
  );

  typedef struct {
    logic        live;
    logic [4:0]  addr;
    logic [31:0] data;
  } ment_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  ment_t       mq[$];
  logic [36:0] exp_q[$];
  logic [4:0]  pres;
  logic [31:0] shadow[32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) if (mq[i].live) m[mq[i].addr] = 1'b1;
    if (pres != 5'd0) m[pres] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  // One clock of stimulus; the model predicts which write lands on rf_* next.
  task automatic cyc(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                     input logic mv, input logic [4:0] ma, input logic [31:0] md);
    logic  rdy;
    ment_t e;
    alu_wr    = aw;
    alu_addr  = aa;
    alu_data  = ad;
    mdu_valid = mv;
    mdu_addr  = ma;
    mdu_data  = md;
    rdy = (mq.size() < DEPTH);
    check("mdu_ready", mdu_ready, rdy);
    pres = 5'd0;
    if (aw && aa != 5'd0) begin
      exp_q.push_back({aa, ad});
      foreach (mq[i]) if (mq[i].addr == aa) mq[i].live = 1'b0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.live) begin
        exp_q.push_back({e.addr, e.data});
        pres = e.addr;
      end
    end
    if (mv && rdy && ma != 5'd0) mq.push_back('{live: 1'b1, addr: ma, data: md});
    tick();
    check("pend_mask", pend_mask, model_mask());
  endtask

  always @(negedge clk) begin
    logic [36:0] e;
    if (!reset && rf_wr) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else e = '1;
      check("wb_write", {rf_waddr, rf_wdata}, e);
      shadow[rf_waddr] = rf_wdata;
    end
  end

  initial begin
    reset     = 1'b1;
    alu_wr    = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mdu_valid = 1'b0;
    mdu_addr  = '0;
    mdu_data  = '0;
    pres      = '0;
    foreach (shadow[i]) shadow[i] = '0;
    tick();
    tick();
    check("rst_rf_wr", rf_wr, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_pend", pend_mask, 0);
    check("rst_ready", mdu_ready, 1);
    reset = 1'b0;
    tick();

    // ALU write latency
    cyc(1, 5, 32'h1234, 0, 0, 0);
    check("alu_rf_wr", rf_wr, 1);
    check("alu_rf_waddr", rf_waddr, 5);
    check("alu_rf_wdata", rf_wdata, 32'h1234);
    cyc(0, 0, 0, 0, 0, 0);

    // MDU results wait behind a busy ALU, then drain in order
    cyc(1, 1, 32'h11, 1, 7, 32'hA);
    cyc(1, 2, 32'h22, 1, 8, 32'hB);
    cyc(1, 3, 32'h33, 0, 0, 0);
    check("pend_7_8", pend_mask[8:7], 2'b11);
    cyc(0, 0, 0, 0, 0, 0);
    check("mdu7_addr", rf_waddr, 7);
    check("mdu7_data", rf_wdata, 32'hA);
    cyc(0, 0, 0, 0, 0, 0);
    check("mdu8_addr", rf_waddr, 8);
    cyc(0, 0, 0, 0, 0, 0);
    check("pend_8_clear", pend_mask[8], 0);

    // Fill, blocked push, then pop+push with pointer wrap
    for (int i = 0; i < DEPTH; i++) cyc(1, 1, i, 1, 5'(10 + i), 32'h100 + i);
    check("full_ready", mdu_ready, 0);
    cyc(1, 2, 32'h5, 1, 14, 32'hDEAD);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 5'(14 + i), 32'h200 + i);
    repeat (6) cyc(0, 0, 0, 0, 0, 0);
    check("wrap_last", shadow[19], 32'h205);
    check("wrap_first", shadow[10], 32'h100);

    // WAW squash, then same-cycle ALU + enqueue to the same register
    cyc(1, 1, 32'h1, 1, 9, 32'h1);
    cyc(1, 9, 32'h2, 0, 0, 0);
    check("squash_pend9", pend_mask[9], 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("squash_drain_wr", rf_wr, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("squash_final9", shadow[9], 32'h2);
    cyc(1, 9, 32'h3, 1, 9, 32'h4);
    check("same_cyc_pend9", pend_mask[9], 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("same_cyc_final9", shadow[9], 32'h4);

    // Writes to $0 are dropped
    cyc(1, 0, 32'hBAD, 1, 0, 32'hBAD);
    check("zero_rf_wr", rf_wr, 0);
    check("zero_pend0", pend_mask[0], 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("zero_rf_wr2", rf_wr, 0);

    // Reset with three queued entries
    cyc(1, 1, 32'h7, 1, 20, 32'h20);
    cyc(1, 2, 32'h8, 1, 21, 32'h21);
    cyc(1, 3, 32'h9, 1, 22, 32'h22);
    @(negedge clk);
    #1;
    reset     = 1'b1;
    alu_wr    = 1'b0;
    mdu_valid = 1'b0;
    #1;
    check("mid_rst_rf_wr", rf_wr, 0);
    check("mid_rst_pend", pend_mask, 0);
    mq.delete();
    pres = 5'd0;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) cyc(0, 0, 0, 0, 0, 0);
    check("rst_no_w20", shadow[20], 0);
    check("rst_no_w22", shadow[22], 0);
    check("sb_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
